pipe_stall_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the in-order CPU.
- Merges per-requester stall requests into a prefix stall bus.
- Derives bubble-insert strobes and generates registered flush/redirect pulses.
- Runs a stall watchdog.
- Sits beside IF/ID/EX/MEM/WB; its outputs drive every pipeline register and the PC unit.

---
 rtl/pipe_stall_ctrl_pkg.sv | 20 ++
 rtl/pipe_stall_ctrl_if.sv | 30 +++
 rtl/pipe_stall_ctrl_stall_watchdog.sv | 48 ++++
 rtl/pipe_stall_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller.
//   - Stall bus width, requester indices, default per-requester stall
//     depths and default flush mask.
//   - Watchdog counter width (covers TIMEOUT up to 2^16-1).
package pipe_stall_ctrl_pkg;

  localparam int STALL_W  = 6;
  localparam int WD_CNT_W = 16;

  // Requester index constants (bit position in stallreq).
  localparam int REQ_EX   = 0;
  localparam int REQ_BRU  = 1;
  localparam int REQ_LOAD = 2;

  // One 4-bit depth per requester; field i stalls bits [LEVEL_i-1:0].
  // req0=EX stalls 4 stages, req1=BRU 3, req2=LOAD 2.
  localparam logic [11:0]        DEF_REQ_LEVEL  = {4'd2, 4'd3, 4'd4};
  localparam logic [STALL_W-1:0] DEF_FLUSH_MASK = 6'b011110;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle between the pipeline stages and the hazard controller.
//   master : pipeline side, raises stall/flush requests, consumes controls.
//   slave  : hazard controller.
// Handshake: flush_req is a one-cycle valid qualifying flush_pc; there is
// no ready -- the controller accepts every request on the edge it is seen.
// stallreq is a level request, honoured in the same cycle.
interface pipe_stall_ctrl_if #(
  parameter int STAGES = 6,
  parameter int NREQ   = 3
);
  logic [NREQ-1:0]   stallreq;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] flush;
  logic              new_pc_valid;
  logic [31:0]       new_pc;
  logic              stall_timeout;

  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, bubble, flush, new_pc_valid, new_pc, stall_timeout
  );

  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, bubble, flush, new_pc_valid, new_pc, stall_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl_stall_watchdog.sv
// Saturating stall-cycle counter with a sticky timeout flag.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   active      : PC is held this cycle (count)
//   clear       : flush accepted this cycle (clears count and flag)
//   timeout     : sticky flag, set on the edge the count reaches TIMEOUT
module stall_watchdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic active,
  input  logic clear,
  output logic timeout
);
  localparam logic [WD_CNT_W-1:0] LIMIT = WD_CNT_W'(TIMEOUT);

  logic [WD_CNT_W-1:0] cnt_q, cnt_d;
  logic                flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (!active) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
      if (cnt_d == LIMIT) flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout = flag_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stall requests into a prefix hold mask,
// derives bubble strobes, registers flush/redirect pulses, runs a watchdog.
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   bus (slave)    : stallreq/flush_req/flush_pc in; stall/bubble (comb),
//                    flush/new_pc_valid/new_pc (registered), stall_timeout out
//   perf_clr, perf_stall_cnt, perf_flush_cnt : present only when CTRL_PERF_EN
//                    is defined (stall-cycle and flush counters)
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int                  STAGES     = STALL_W,
  parameter int                  NREQ       = 3,
  parameter logic [4*NREQ-1:0]   REQ_LEVEL  = DEF_REQ_LEVEL,
  parameter logic [STAGES-1:0]   FLUSH_MASK = DEF_FLUSH_MASK,
  parameter int                  TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  pipe_stall_ctrl_if.slave       bus
`ifdef CTRL_PERF_EN
  ,
  input  logic                   perf_clr,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt
`endif
);
  logic [STAGES-1:0] stall_w;
  logic [STAGES-1:0] bubble_w;
  logic [STAGES-1:0] flush_q, flush_d;
  logic              npv_q, npv_d;
  logic [31:0]       new_pc_q, new_pc_d;

  // Prefix merge. In STAGES-bit arithmetic (1<<STAGES) wraps to 0, so a
  // level equal to STAGES still yields the all-ones mask.
  always_comb begin
    stall_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.stallreq[i])
        stall_w |= (STAGES'(1) << REQ_LEVEL[4*i +: 4]) - STAGES'(1);
    end
    // A redirect in flight owns the pipeline; reset drops holds at once.
    if (!resetn || npv_q) stall_w = '0;
  end

  // Bubble goes into the first register that keeps moving behind the stall.
  always_comb begin
    bubble_w = '0;
    for (int k = 1; k < STAGES; k++)
      bubble_w[k] = stall_w[k-1] & ~stall_w[k];
  end

  always_comb begin
    flush_d  = bus.flush_req ? FLUSH_MASK : '0;
    npv_d    = bus.flush_req;
    new_pc_d = bus.flush_req ? bus.flush_pc : new_pc_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_q  <= '0;
      npv_q    <= 1'b0;
      new_pc_q <= '0;
    end else begin
      flush_q  <= flush_d;
      npv_q    <= npv_d;
      new_pc_q <= new_pc_d;
    end
  end

  stall_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .resetn  (resetn),
    .active  (stall_w[0]),
    .clear   (bus.flush_req),
    .timeout (bus.stall_timeout)
  );

  assign bus.stall        = stall_w;
  assign bus.bubble       = bubble_w;
  assign bus.flush        = flush_q;
  assign bus.new_pc_valid = npv_q;
  assign bus.new_pc       = new_pc_q;

`ifdef CTRL_PERF_EN
  logic [31:0] pstall_q, pstall_d;
  logic [31:0] pflush_q, pflush_d;

  always_comb begin
    pstall_d = pstall_q + {31'd0, stall_w[0]};
    pflush_d = pflush_q + {31'd0, npv_q};
    if (perf_clr) begin
      pstall_d = '0;
      pflush_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      pstall_q <= pstall_d;
      pflush_q <= pflush_d;
    end
  end

  assign perf_stall_cnt = pstall_q;
  assign perf_flush_cnt = pflush_q;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (TIMEOUT=8, default levels/mask).
module tb_pipe_stall_ctrl;
  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;

  pipe_stall_ctrl_if #(.STAGES(6), .NREQ(3)) bus ();

`ifdef CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_stall_ctrl #(.TIMEOUT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef CTRL_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    resetn        = 1'b0;
    bus.stallreq  = 3'b111;
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'hDEADBEEF;
`ifdef CTRL_PERF_EN
    perf_clr = 1'b0;
`endif

    // reset held with every request active
    repeat (2) tick();
    chk("rst_stall",   {26'd0, bus.stall},  32'h0);
    chk("rst_bubble",  {26'd0, bus.bubble}, 32'h0);
    chk("rst_flush",   {26'd0, bus.flush},  32'h0);
    chk("rst_npv",     {31'd0, bus.new_pc_valid}, 32'h0);
    chk("rst_newpc",   bus.new_pc, 32'h0);
    chk("rst_timeout", {31'd0, bus.stall_timeout}, 32'h0);

    bus.flush_req = 1'b0;
    bus.stallreq  = 3'b000;
    resetn        = 1'b1;
    tick();

    // stall merge (combinational)
    bus.stallreq = 3'b001; #1;
    chk("merge001_stall",  {26'd0, bus.stall},  32'h0F);
    chk("merge001_bubble", {26'd0, bus.bubble}, 32'h10);
    bus.stallreq = 3'b110; #1;
    chk("merge110_stall",  {26'd0, bus.stall},  32'h07);
    chk("merge110_bubble", {26'd0, bus.bubble}, 32'h08);
    bus.stallreq = 3'b100; #1;
    chk("merge100_stall",  {26'd0, bus.stall},  32'h03);
    chk("merge100_bubble", {26'd0, bus.bubble}, 32'h04);
    bus.stallreq = 3'b000; #1;
    chk("merge000_stall",  {26'd0, bus.stall},  32'h00);
    chk("merge000_bubble", {26'd0, bus.bubble}, 32'h00);
    tick();

    // flush with EX stall held
    bus.stallreq  = 3'b001;
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'hBFC00380;
    tick();
    bus.flush_req = 1'b0;
    chk("fl_flush",  {26'd0, bus.flush}, 32'h1E);
    chk("fl_npv",    {31'd0, bus.new_pc_valid}, 32'h1);
    chk("fl_newpc",  bus.new_pc, 32'hBFC00380);
    chk("fl_stall",  {26'd0, bus.stall},  32'h00);
    chk("fl_bubble", {26'd0, bus.bubble}, 32'h00);
    tick();
    chk("fl2_flush",  {26'd0, bus.flush}, 32'h00);
    chk("fl2_npv",    {31'd0, bus.new_pc_valid}, 32'h0);
    chk("fl2_newpc",  bus.new_pc, 32'hBFC00380);
    chk("fl2_stall",  {26'd0, bus.stall},  32'h0F);
    chk("fl2_bubble", {26'd0, bus.bubble}, 32'h10);

    // back-to-back flushes
    bus.stallreq  = 3'b000;
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'h12345678;
    tick();
    chk("b2b_a_npv",   {31'd0, bus.new_pc_valid}, 32'h1);
    chk("b2b_a_newpc", bus.new_pc, 32'h12345678);
    chk("b2b_a_flush", {26'd0, bus.flush}, 32'h1E);
    bus.flush_pc = 32'hCAFEF00D;
    tick();
    bus.flush_req = 1'b0;
    chk("b2b_b_npv",   {31'd0, bus.new_pc_valid}, 32'h1);
    chk("b2b_b_newpc", bus.new_pc, 32'hCAFEF00D);
    tick();
    chk("b2b_end_npv",   {31'd0, bus.new_pc_valid}, 32'h0);
    chk("b2b_end_flush", {26'd0, bus.flush}, 32'h00);
    chk("b2b_end_newpc", bus.new_pc, 32'hCAFEF00D);

    // watchdog: 8 consecutive stall edges
    bus.stallreq = 3'b001;
    repeat (7) tick();
    chk("wd_edge7", {31'd0, bus.stall_timeout}, 32'h0);
    tick();
    chk("wd_edge8", {31'd0, bus.stall_timeout}, 32'h1);
    bus.stallreq = 3'b000;
    tick();
    chk("wd_sticky1", {31'd0, bus.stall_timeout}, 32'h1);
    repeat (3) tick();
    chk("wd_sticky4", {31'd0, bus.stall_timeout}, 32'h1);
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'h00000100;
    tick();
    bus.flush_req = 1'b0;
    chk("wd_clr", {31'd0, bus.stall_timeout}, 32'h0);
    tick();

    // reset during a flush pulse and during a stall
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'h13572468;
    bus.stallreq  = 3'b001;
    tick();
    bus.flush_req = 1'b0;
    chk("rmf_npv_before", {31'd0, bus.new_pc_valid}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("rmf_npv",   {31'd0, bus.new_pc_valid}, 32'h0);
    chk("rmf_flush", {26'd0, bus.flush}, 32'h00);
    chk("rmf_newpc", bus.new_pc, 32'h0);
    chk("rmf_stall", {26'd0, bus.stall}, 32'h00);
    #2;
    resetn = 1'b1;
    tick();
    chk("post_rst_stall", {26'd0, bus.stall}, 32'h0F);
    bus.stallreq = 3'b000;
    tick();

`ifdef CTRL_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr0_stall", perf_stall_cnt, 32'd0);
    chk("perf_clr0_flush", perf_flush_cnt, 32'd0);
    bus.stallreq = 3'b001;
    repeat (5) tick();
    bus.stallreq = 3'b000;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick();
    chk("perf_stall5", perf_stall_cnt, 32'd5);
    chk("perf_flush2", perf_flush_cnt, 32'd2);
    perf_clr     = 1'b1;
    bus.stallreq = 3'b001;
    tick();
    perf_clr     = 1'b0;
    bus.stallreq = 3'b000;
    chk("perf_clr_stall", perf_stall_cnt, 32'd0);
    chk("perf_clr_flush", perf_flush_cnt, 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
